// File: rtl/scene_byte_unpacker.sv
// Expands a host byte stream into single-voxel load beats for one full scene (2^ADDR_BITS voxels).
// Optional occupied-voxel counter enabled by defining SCENE_UNPACK_OCC_COUNT_EN.
module scene_byte_unpacker #(
  parameter int ADDR_BITS = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 in_valid,
  input  logic [7:0]           in_data,
  output logic                 in_ready,
  output logic                 load_mode,
  output logic                 load_valid,
  output logic [ADDR_BITS-1:0] load_addr,
  output logic                 load_data,
  input  logic                 load_ready,
  output logic                 busy,
  output logic                 done,
  output logic [ADDR_BITS:0]   occupied_count
);

  typedef enum logic [1:0] {IDLE, WAIT_BYTE, SHIFT, DONE} state_t;

  localparam logic [ADDR_BITS-1:0] ADDR_MAX = '1;

  state_t               state, state_nxt;
  logic [7:0]           byte_reg, byte_nxt;
  logic [2:0]           bit_idx, bit_nxt;
  logic [ADDR_BITS-1:0] addr_cnt, addr_nxt;
  logic                 last_bit, at_max, beat_acc, byte_acc;

  assign last_bit   = (bit_idx == 3'd7);
  assign at_max     = (addr_cnt == ADDR_MAX);
  assign load_valid = (state == SHIFT);
  assign load_mode  = (state != IDLE);
  assign load_addr  = addr_cnt;
  assign load_data  = byte_reg[bit_idx];
  assign busy       = (state == WAIT_BYTE) || (state == SHIFT);
  assign done       = (state == DONE);

  // A byte may also be taken while the last bit of the previous one is leaving, so bytes stream without bubbles.
  assign in_ready = !abort && ((state == WAIT_BYTE) ||
                               (load_valid && last_bit && load_ready && !at_max));
  assign beat_acc = load_valid && load_ready && !abort;
  assign byte_acc = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      byte_reg <= '0;
      bit_idx  <= '0;
      addr_cnt <= '0;
    end else begin
      state    <= state_nxt;
      byte_reg <= byte_nxt;
      bit_idx  <= bit_nxt;
      addr_cnt <= addr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    byte_nxt  = byte_reg;
    bit_nxt   = bit_idx;
    addr_nxt  = addr_cnt;
    if (abort) begin
      state_nxt = IDLE;
      bit_nxt   = '0;
      addr_nxt  = '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state_nxt = WAIT_BYTE;
            bit_nxt   = '0;
            addr_nxt  = '0;
          end
        end
        WAIT_BYTE: begin
          if (byte_acc) begin
            byte_nxt  = in_data;
            bit_nxt   = '0;
            state_nxt = SHIFT;
          end
        end
        SHIFT: begin
          if (beat_acc) begin
            addr_nxt = addr_cnt + 1'b1;
            bit_nxt  = bit_idx + 3'd1;
            if (last_bit) begin
              if (at_max)        state_nxt = DONE;
              else if (byte_acc) byte_nxt  = in_data;
              else               state_nxt = WAIT_BYTE;
            end
          end
        end
        DONE: begin
          if (start) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

`ifdef SCENE_UNPACK_OCC_COUNT_EN
  logic [ADDR_BITS:0] occ_cnt;

  // One bit wider than the address so an all-occupied scene does not wrap.
  always_ff @(posedge clk) begin
    if (rst || abort || (state == IDLE && start)) occ_cnt <= '0;
    else if (beat_acc && load_data)               occ_cnt <= occ_cnt + 1'b1;
  end

  assign occupied_count = occ_cnt;
`else
  assign occupied_count = '0;
`endif

endmodule

// File: tb/tb_scene_byte_unpacker.sv
// Bench for scene_byte_unpacker at ADDR_BITS=6: directed scene loads with random stimulus,
// checked against a beat/byte-count reference model.
module tb_scene_byte_unpacker;
  localparam int AB     = 6;
  localparam int NBEATS = 1 << AB;
`ifdef SCENE_UNPACK_OCC_COUNT_EN
  localparam bit OCC_EN = 1'b1;
`else
  localparam bit OCC_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, start, abort, in_valid, load_ready;
  logic [7:0]    in_data;
  logic          in_ready, load_mode, load_valid, load_data, busy, done;
  logic [AB-1:0] load_addr;
  logic [AB:0]   occupied_count;

  int            npass  = 0;
  int            ntotal = 0;
  int            exp_occ = 0;
  logic [7:0]    bytes [8];

  scene_byte_unpacker #(.ADDR_BITS(AB)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .load_mode(load_mode), .load_valid(load_valid), .load_addr(load_addr),
    .load_data(load_data), .load_ready(load_ready),
    .busy(busy), .done(done), .occupied_count(occupied_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] occ_view(input int v);
    return OCC_EN ? 32'(v) : 32'd0;
  endfunction

  // mode 0: continuous traffic; 1: random valid/ready/start; 2: byte gap + backpressure at addr 13
  task automatic run_load(input int mode, input int abort_beat);
    int   beat, acc, gap, bp, first_v, done_cyc;
    bit   finished, aborted;
    logic exp_lv, exp_ir, abort_now;
    beat = 0; acc = 0; gap = 0; bp = 0; first_v = -1; done_cyc = 0;
    finished = 0; aborted = 0;
    @(negedge clk);
    start = 1'b1; abort = 1'b0; in_valid = 1'b0; load_ready = 1'b1;
    #1;
    check("idle_in_ready", in_ready, 0);
    check("idle_mode", load_mode, 0);
    check("idle_occ_held", occupied_count, occ_view(exp_occ));
    exp_occ = 0;
    for (int cyc = 0; cyc < 2000 && !finished && !aborted; cyc++) begin
      @(negedge clk);
      exp_lv = (acc * 8 > beat);
      case (mode)
        0: in_valid = 1'b1;
        2: begin
          in_valid = !(acc == 2 && beat >= 15 && gap < 3);
          if (acc == 2 && beat == 16 && gap < 3) gap++;
        end
        default: in_valid = ($urandom % 10 < 7);
      endcase
      in_data = (acc < 8) ? bytes[acc] : 8'($urandom);
      if (mode == 0) load_ready = 1'b1;
      else if (mode == 2) begin
        if (beat == 13 && exp_lv && bp < 2) begin
          load_ready = 1'b0;
          bp++;
        end else load_ready = 1'b1;
      end else load_ready = ($urandom % 10 < 7);
      abort_now = (abort_beat >= 0 && beat == abort_beat && exp_lv);
      abort     = abort_now;
      start     = (mode != 0) && !abort_now && (beat < NBEATS) && ($urandom % 8 == 0);
      exp_ir    = !abort_now && (beat < NBEATS) &&
                  ((acc * 8 == beat) ||
                   (acc * 8 == beat + 1 && load_ready && beat + 1 < NBEATS));
      #1;
      check("load_mode", load_mode, 1);
      check("load_valid", load_valid, exp_lv);
      if (exp_lv) begin
        check("load_addr", load_addr, beat);
        check("load_data", load_data, bytes[beat / 8][beat % 8]);
      end
      check("in_ready", in_ready, exp_ir);
      check("done", done, beat == NBEATS);
      check("busy", busy, beat < NBEATS);
      check("occ", occupied_count, occ_view(exp_occ));
      if (exp_lv && first_v < 0) first_v = cyc;
      if (abort_now) aborted = 1;
      else if (beat == NBEATS) begin
        finished = 1;
        done_cyc = cyc;
      end else begin
        if (in_valid && exp_ir) acc++;
        if (exp_lv && load_ready) begin
          exp_occ += int'(bytes[beat / 8][beat % 8]);
          beat++;
        end
      end
    end
    check("load_budget", finished || aborted, 1);
    if (aborted) begin
      @(negedge clk);
      abort = 1'b0; start = 1'b0; in_valid = 1'b1;
      exp_occ = 0;
      #1;
      check("abort_mode", load_mode, 0);
      check("abort_valid", load_valid, 0);
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_in_ready", in_ready, 0);
      check("abort_occ", occupied_count, occ_view(exp_occ));
    end else if (finished) begin
      if (mode == 0) check("throughput", done_cyc - first_v, NBEATS);
      repeat (2) begin
        @(negedge clk);
        in_valid = 1'b1; start = 1'b0; abort = 1'b0; in_data = 8'($urandom);
        #1;
        check("done_hold", done, 1);
        check("done_in_ready", in_ready, 0);
        check("done_valid", load_valid, 0);
        check("done_mode", load_mode, 1);
        check("done_occ", occupied_count, occ_view(exp_occ));
      end
      @(negedge clk);
      start = 1'b1; in_valid = 1'b0;
      #1;
      check("done_before_exit", done, 1);
      @(negedge clk);
      start = 1'b0;
      #1;
      check("exit_mode", load_mode, 0);
      check("exit_done", done, 0);
      check("exit_occ_held", occupied_count, occ_view(exp_occ));
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b1;
    in_data = 8'hFF; load_ready = 1'b1;
    repeat (2) begin
      @(negedge clk);
      #1;
      check("rst_mode", load_mode, 0);
      check("rst_valid", load_valid, 0);
      check("rst_in_ready", in_ready, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_occ", occupied_count, 0);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_mode", load_mode, 0);
    check("post_rst_in_ready", in_ready, 0);

    bytes = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h01, 8'h80, 8'h5A, 8'hC3};
    run_load(0, -1);
    run_load(2, -1);

    for (int i = 0; i < 8; i++) bytes[i] = 8'($urandom);
    run_load(1, 20);
    run_load(0, -1);
    for (int i = 0; i < 8; i++) bytes[i] = 8'($urandom);
    run_load(1, -1);

    for (int i = 0; i < 8; i++) bytes[i] = 8'hFF;
    run_load(1, -1);
    run_load(0, 20);
    for (int i = 0; i < 8; i++) bytes[i] = 8'h01;
    run_load(0, -1);

    @(negedge clk);
    start = 1'b1; abort = 1'b1; in_valid = 1'b1;
    #1;
    check("sa_in_ready", in_ready, 0);
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    #1;
    check("sa_mode", load_mode, 0);
    check("sa_busy", busy, 0);
    check("sa_occ", occupied_count, occ_view(exp_occ));

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end
endmodule
